// File: rtl/mixpix_readout_seq.sv
// Readout sequencer for the mixed-signal pixel array: drives the front-end strobes,
// runs a single-slope conversion per photodiode, and returns results over valid/ready.
module mixpix_readout_seq #(
  parameter int unsigned NPIX  = 12,
  parameter int unsigned CW    = 10,
  parameter int unsigned T_RST = 8,
  parameter int unsigned T_SH  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     int_time,
  input  logic            cmp_in,
  output logic            sw1,
  output logic            sw2,
  output logic            sh,
  output logic            sh_cmp,
  output logic            sh_rst,
  output logic [NPIX-1:0] pd_sel,
  output logic [CW-1:0]   ramp_code,
  output logic [CW-1:0]   data_out,
  output logic [3:0]      pix_idx,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_INT, S_SAMP, S_CONV, S_OUT, S_DONE
  } state_t;

  localparam logic [15:0]   RST_LAST = 16'(T_RST - 1);
  localparam logic [15:0]   SH_LAST  = 16'(T_SH - 1);
  localparam logic [3:0]    PIX_LAST = 4'(NPIX - 1);
  localparam logic [CW-1:0] RAMP_MAX = '1;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       tint_q, tint_d;
  logic [3:0]        pix_q, pix_d;
  logic [CW-1:0]     ramp_q, ramp_d;
  logic [CW-1:0]     dout_q, dout_d;
  logic              cmp_meta_q, cmp_s_q;
  logic              rst_ph_q, rst_ph_d;
  logic              samp_ph_q, samp_ph_d;
  logic              conv_ph_q, conv_ph_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NPIX-1:0]   pd_sel_q, pd_sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta_q <= 1'b0;
      cmp_s_q    <= 1'b0;
    end else begin
      cmp_meta_q <= cmp_in;
      cmp_s_q    <= cmp_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tint_d  = tint_q;
    pix_d   = pix_q;
    ramp_d  = ramp_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        ramp_d = '0;
        if (start) begin
          tint_d  = (int_time == 16'd0) ? 16'd1 : int_time;
          pix_d   = '0;
          cnt_d   = '0;
          state_d = S_RST;
        end
      end
      S_RST: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == tint_q - 16'd1) begin
          cnt_d   = '0;
          state_d = S_SAMP;
        end
      end
      S_SAMP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SH_LAST) begin
          cnt_d   = '0;
          ramp_d  = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // Result is whatever code is on the ramp when the synchronised comparator is seen.
        if (cmp_s_q) begin
          dout_d  = ramp_q;
          state_d = S_OUT;
        end else if (ramp_q == RAMP_MAX) begin
          dout_d  = RAMP_MAX;
          state_d = S_OUT;
        end else begin
          ramp_d = ramp_q + CW'(1);
        end
      end
      S_OUT: begin
        if (data_ready) begin
          if (pix_q == PIX_LAST) begin
            state_d = S_DONE;
          end else begin
            pix_d   = pix_q + 4'd1;
            cnt_d   = '0;
            state_d = S_RST;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    rst_ph_d  = (state_d == S_RST);
    samp_ph_d = (state_d == S_SAMP);
    conv_ph_d = (state_d == S_CONV);
    valid_d   = (state_d == S_OUT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    pd_sel_d  = (state_d != S_IDLE) ? (NPIX'(1) << pix_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tint_q    <= '0;
      pix_q     <= '0;
      ramp_q    <= '0;
      dout_q    <= '0;
      rst_ph_q  <= 1'b0;
      samp_ph_q <= 1'b0;
      conv_ph_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pd_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tint_q    <= tint_d;
      pix_q     <= pix_d;
      ramp_q    <= ramp_d;
      dout_q    <= dout_d;
      rst_ph_q  <= rst_ph_d;
      samp_ph_q <= samp_ph_d;
      conv_ph_q <= conv_ph_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pd_sel_q  <= pd_sel_d;
    end
  end

  assign sw1        = rst_ph_q;
  assign sh_rst     = rst_ph_q;
  assign sw2        = samp_ph_q;
  assign sh         = samp_ph_q;
  assign sh_cmp     = conv_ph_q;
  assign pd_sel     = pd_sel_q;
  assign ramp_code  = ramp_q;
  assign data_out   = dout_q;
  assign pix_idx    = pix_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
